// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC control unit.
package multicycle_ctrl_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned WB_SRC_W = 2;
  localparam int unsigned ALU_OP_W = 2;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h4;
  localparam logic [OPC_W-1:0] OP_SUBI = 4'h5;
  localparam logic [OPC_W-1:0] OP_LDR  = 4'h6;
  localparam logic [OPC_W-1:0] OP_STR  = 4'h7;
  localparam logic [OPC_W-1:0] OP_B    = 4'h8;
  localparam logic [OPC_W-1:0] OP_BZ   = 4'h9;
  localparam logic [OPC_W-1:0] OP_JAL  = 4'hA;
  localparam logic [OPC_W-1:0] OP_JR   = 4'hB;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  localparam logic [PC_SRC_W-1:0] PC_INC  = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_REL  = 2'd1;
  localparam logic [PC_SRC_W-1:0] PC_REG  = 2'd2;
  localparam logic [PC_SRC_W-1:0] PC_TRAP = 2'd3;

  localparam logic [WB_SRC_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_SRC_W-1:0] WB_MDR = 2'd1;
  localparam logic [WB_SRC_W-1:0] WB_PC  = 2'd2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 2'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'd3;

  typedef enum logic [2:0] {
    ST_BOOT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_RTYPE, CL_IMM, CL_MEM, CL_B, CL_BZ, CL_JAL, CL_JR, CL_HALT, CL_ILLEGAL
  } op_class_t;

  typedef struct packed {
    op_class_t             cls;
    logic                  imm_5or8;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  is_illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath/memory bundle; master = controller side.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [INSTR_W-1:0]  instr;
  logic                zero_flag;
  logic                mem_ack;
  logic                mem_req;
  logic                mem_we;
  logic                mem_addr_src;
  logic                ir_load;
  logic                mdr_load;
  logic                pc_write;
  logic [PC_SRC_W-1:0] pc_src;
  logic                imm_5or8;
  logic                alu_src_imm;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_write;
  logic                reg_dst_r7;
  logic [WB_SRC_W-1:0] wb_src;
  logic                halted;
  logic                bus_err;

  modport master (
    input  instr, zero_flag, mem_ack,
    output mem_req, mem_we, mem_addr_src, ir_load, mdr_load, pc_write, pc_src,
           imm_5or8, alu_src_imm, alu_op, reg_write, reg_dst_r7, wb_src, halted, bus_err
  );

  modport slave (
    output instr, zero_flag, mem_ack,
    input  mem_req, mem_we, mem_addr_src, ir_load, mdr_load, pc_write, pc_src,
           imm_5or8, alu_src_imm, alu_op, reg_write, reg_dst_r7, wb_src, halted, bus_err
  );
endinterface

// File: rtl/multicycle_ctrl_op_decode.sv
// Combinational opcode classifier: class, immediate width, ALU op, illegal flag.
module multicycle_ctrl_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_t             dec
);

  always_comb begin
    dec.cls        = CL_ILLEGAL;
    dec.imm_5or8   = 1'b0;
    dec.alu_op     = ALU_ADD;
    dec.is_illegal = 1'b0;
    case (opcode)
      OP_ADD:  dec.cls = CL_RTYPE;
      OP_SUB:  begin dec.cls = CL_RTYPE; dec.alu_op = ALU_SUB; end
      OP_AND:  begin dec.cls = CL_RTYPE; dec.alu_op = ALU_AND; end
      OP_OR:   begin dec.cls = CL_RTYPE; dec.alu_op = ALU_OR;  end
      OP_ADDI: dec.cls = CL_IMM;
      OP_SUBI: begin dec.cls = CL_IMM; dec.alu_op = ALU_SUB; end
      OP_LDR, OP_STR: dec.cls = CL_MEM;
      OP_B:    begin dec.cls = CL_B;   dec.imm_5or8 = 1'b1; end
      OP_BZ:   begin dec.cls = CL_BZ;  dec.imm_5or8 = 1'b1; end
      OP_JAL:  begin dec.cls = CL_JAL; dec.imm_5or8 = 1'b1; end
      OP_JR:   dec.cls = CL_JR;
      OP_HALT: dec.cls = CL_HALT;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM with shared memory-port arbitration and request timeout.
// Build option: CTRL_ILLEGAL_TRAP_EN turns illegal opcodes into a trap instead of a NOP.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t             state_q, state_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dec_t               dec;
  logic               at_limit_c;
  logic               unused_instr;

  assign unused_instr = ^bus.instr[INSTR_W-OPC_W-1:0];
  assign at_limit_c   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  multicycle_ctrl_op_decode u_dec (.opcode(opcode_q), .dec(dec));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    opcode_d         = opcode_q;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_src = 1'b0;
    bus.ir_load      = 1'b0;
    bus.mdr_load     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = PC_INC;
    bus.imm_5or8     = 1'b0;
    bus.alu_src_imm  = 1'b0;
    bus.alu_op       = ALU_ADD;
    bus.reg_write    = 1'b0;
    bus.reg_dst_r7   = 1'b0;
    bus.wb_src       = WB_ALU;
    bus.halted       = 1'b0;
    bus.bus_err      = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_load  = 1'b1;
          bus.pc_write = 1'b1;
          opcode_d     = bus.instr[INSTR_W-1 -: OPC_W];
          state_d      = ST_DECODE;
        end else if (at_limit_c) begin
          bus.bus_err = 1'b1;
          state_d     = ST_HALT;
        end
      end

      ST_DECODE: begin
        bus.imm_5or8 = dec.imm_5or8;
        state_d      = ST_EXEC;
      end

      ST_EXEC: begin
        bus.imm_5or8 = dec.imm_5or8;
        state_d      = ST_FETCH;
        if (dec.is_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          bus.pc_write   = 1'b1;
          bus.pc_src     = PC_TRAP;
          bus.reg_write  = 1'b1;
          bus.reg_dst_r7 = 1'b1;
          bus.wb_src     = WB_PC;
`endif
        end else begin
          case (dec.cls)
            CL_RTYPE: begin bus.alu_op = dec.alu_op; state_d = ST_WB; end
            CL_IMM: begin
              bus.alu_op      = dec.alu_op;
              bus.alu_src_imm = 1'b1;
              state_d         = ST_WB;
            end
            CL_MEM:  begin bus.alu_src_imm = 1'b1; state_d = ST_MEM; end
            CL_B:    begin bus.pc_write = 1'b1; bus.pc_src = PC_REL; end
            CL_BZ:   begin bus.pc_write = bus.zero_flag; bus.pc_src = PC_REL; end
            CL_JAL: begin
              bus.reg_write  = 1'b1;
              bus.reg_dst_r7 = 1'b1;
              bus.wb_src     = WB_PC;
              bus.pc_write   = 1'b1;
              bus.pc_src     = PC_REL;
            end
            CL_JR:   begin bus.pc_write = 1'b1; bus.pc_src = PC_REG; end
            CL_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
          endcase
        end
      end

      ST_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_src = 1'b1;
        bus.mem_we       = (opcode_q == OP_STR);
        if (bus.mem_ack) begin
          if (opcode_q == OP_STR) begin
            state_d = ST_FETCH;
          end else begin
            bus.mdr_load = 1'b1;
            state_d      = ST_WB;
          end
        end else if (at_limit_c) begin
          bus.bus_err = 1'b1;
          state_d     = ST_HALT;
        end
      end

      ST_WB: begin
        bus.reg_write = 1'b1;
        bus.wb_src    = (opcode_q == OP_LDR) ? WB_MDR : WB_ALU;
        state_d       = ST_FETCH;
      end

      ST_HALT: bus.halted = 1'b1;

      default: state_d = ST_BOOT;
    endcase

    // Wait counter only advances while one request is still outstanding
    if (bus.mem_req && !bus.mem_ack && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: per-cycle expected control vectors from an instruction-level model.
module tb_multicycle_ctrl;

  localparam int unsigned T = 16;

  typedef struct packed {
    logic       mem_req, mem_we, mem_addr_src, ir_load, mdr_load, pc_write;
    logic [1:0] pc_src;
    logic       imm_5or8, alu_src_imm;
    logic [1:0] alu_op;
    logic       reg_write, reg_dst_r7;
    logic [1:0] wb_src;
    logic       halted, bus_err;
  } ctl_t;

  typedef struct {
    int unsigned cyc;
    ctl_t        exp;
    logic [3:0]  op;
    int          ph;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  sb_t         exp_q[$];
  ctl_t        act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_ctrl_if mif();
  multicycle_ctrl #(.TIMEOUT_CYC(T)) dut (.clk(clk), .rst(rst), .bus(mif));

  assign act = {mif.mem_req, mif.mem_we, mif.mem_addr_src, mif.ir_load, mif.mdr_load,
                mif.pc_write, mif.pc_src, mif.imm_5or8, mif.alu_src_imm, mif.alu_op,
                mif.reg_write, mif.reg_dst_r7, mif.wb_src, mif.halted, mif.bus_err};

  // Reference model: what each instruction phase must drive
  function automatic ctl_t m_req(input logic data, input logic ack, input logic [3:0] op);
    ctl_t c = '0;
    c.mem_req      = 1'b1;
    c.mem_addr_src = data;
    if (!data && ack) begin c.ir_load = 1'b1; c.pc_write = 1'b1; end
    if (data) begin
      c.mem_we   = (op == 4'h7);
      c.mdr_load = ack && (op == 4'h6);
    end
    return c;
  endfunction

  function automatic logic uses_imm8(input logic [3:0] op);
    return (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
  endfunction

  function automatic ctl_t m_dec(input logic [3:0] op);
    ctl_t c = '0;
    c.imm_5or8 = uses_imm8(op);
    return c;
  endfunction

  function automatic ctl_t m_exec(input logic [3:0] op, input logic zf);
    ctl_t c = '0;
    c.imm_5or8 = uses_imm8(op);
    case (op)
      4'h0: c.alu_op = 2'd0;
      4'h1: c.alu_op = 2'd1;
      4'h2: c.alu_op = 2'd2;
      4'h3: c.alu_op = 2'd3;
      4'h4, 4'h6, 4'h7: c.alu_src_imm = 1'b1;
      4'h5: begin c.alu_src_imm = 1'b1; c.alu_op = 2'd1; end
      4'h8: begin c.pc_write = 1'b1; c.pc_src = 2'd1; end
      4'h9: begin c.pc_write = zf; c.pc_src = 2'd1; end
      4'hA: begin
        c.reg_write = 1'b1; c.reg_dst_r7 = 1'b1; c.wb_src = 2'd2;
        c.pc_write = 1'b1; c.pc_src = 2'd1;
      end
      4'hB: begin c.pc_write = 1'b1; c.pc_src = 2'd2; end
      4'hF: c = '0;
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        c.pc_write = 1'b1; c.pc_src = 2'd3;
        c.reg_write = 1'b1; c.reg_dst_r7 = 1'b1; c.wb_src = 2'd2;
`endif
      end
    endcase
    return c;
  endfunction

  function automatic ctl_t m_wb(input logic [3:0] op);
    ctl_t c = '0;
    c.reg_write = 1'b1;
    c.wb_src    = (op == 4'h6) ? 2'd1 : 2'd0;
    return c;
  endfunction

  function automatic ctl_t m_halt();
    ctl_t c = '0;
    c.halted = 1'b1;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and queue the vector the DUT must show in it
  task automatic step(input logic ack, input logic [15:0] ins, input logic zf,
                      input ctl_t e, input logic [3:0] op, input int ph);
    mif.mem_ack   = ack;
    mif.instr     = ins;
    mif.zero_flag = zf;
    exp_q.push_back('{cyc: cyc, exp: e, op: op, ph: ph});
    @(posedge clk);
    #1;
  endtask

  task automatic req_timeout(input logic data, input logic [3:0] op);
    ctl_t e;
    for (int i = 0; i < int'(T) - 1; i++) step(1'b0, 16'($urandom), rb(), m_req(data, 1'b0, op), op, 8);
    e = m_req(data, 1'b0, op);
    e.bus_err = 1'b1;
    step(1'b0, 16'($urandom), rb(), e, op, 8);
    repeat (3) step(rb(), 16'($urandom), rb(), m_halt(), op, 6);
  endtask

  // wm >= T means the data access is never acknowledged
  task automatic run_instr(input logic [3:0] op, input int wf, input int wm, input logic zf);
    for (int i = 0; i < wf; i++) step(1'b0, 16'($urandom), rb(), m_req(1'b0, 1'b0, op), op, 1);
    step(1'b1, {op, 12'($urandom)}, rb(), m_req(1'b0, 1'b1, op), op, 1);
    step(rb(), 16'($urandom), rb(), m_dec(op), op, 2);
    step(rb(), 16'($urandom), zf, m_exec(op, zf), op, 3);
    if (op == 4'h6 || op == 4'h7) begin
      if (wm >= int'(T)) begin
        req_timeout(1'b1, op);
      end else begin
        for (int i = 0; i < wm; i++) step(1'b0, 16'($urandom), rb(), m_req(1'b1, 1'b0, op), op, 4);
        step(1'b1, 16'($urandom), rb(), m_req(1'b1, 1'b1, op), op, 4);
        if (op == 4'h6) step(rb(), 16'($urandom), rb(), m_wb(op), op, 5);
      end
    end else if (op <= 4'h5) begin
      step(rb(), 16'($urandom), rb(), m_wb(op), op, 5);
    end
  endtask

  // Assert reset from wherever the FSM is, then release into BOOT
  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 16'($urandom), rb(), '0, 4'h0, 7);
    step(1'b1, 16'($urandom), rb(), '0, 4'h0, 7);
    rst = 1'b0;
    step(1'b1, 16'($urandom), rb(), '0, 4'h0, 0);
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL missed_check op=%h phase=%0d cyc=%0d", e.op, e.ph, e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL ctl op=%h phase=%0d cyc=%0d actual=%h required=%h",
                   e.op, e.ph, cyc, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] op;
    mif.mem_ack = 1'b1; mif.instr = '0; mif.zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(4'h4, 0, 0, 1'b0);
    run_instr(4'h6, 0, 3, 1'b0);
    run_instr(4'h9, 0, 0, 1'b0);
    run_instr(4'h9, 0, 0, 1'b1);
    run_instr(4'hA, 1, 0, 1'b0);
    run_instr(4'hC, 0, 0, 1'b0);
    run_instr(4'hE, 2, 0, 1'b1);
    run_instr(4'h7, 1, 2, 1'b0);
    run_instr(4'hB, 0, 0, 1'b0);
    run_instr(4'h0, int'(T) - 1, 0, 1'b0);
    run_instr(4'h6, 0, int'(T) - 1, 1'b0);

    repeat (60) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());
    end

    run_instr(4'hF, 0, 0, 1'b0);
    repeat (3) step(rb(), 16'($urandom), rb(), m_halt(), 4'hF, 6);

    do_reset();
    req_timeout(1'b0, 4'h0);

    do_reset();
    step(1'b0, 16'($urandom), rb(), m_req(1'b0, 1'b0, 4'h0), 4'h0, 1);
    step(1'b0, 16'($urandom), rb(), m_req(1'b0, 1'b0, 4'h0), 4'h0, 1);
    do_reset();
    run_instr(4'h6, 0, int'(T), 1'b0);

    do_reset();
    run_instr(4'h1, 0, 0, 1'b0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
